// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the reset PC default, instruction size, fetch state and buffer entry layout.
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} entries with flush.
// The head is read straight from storage, so a push becomes visible the cycle after.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order requests,
// buffers responses with their PCs and handles redirects by flushing and dropping.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misaligned_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic          err_q, err_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          pop, accept, rsp_push;
    logic          fifo_full, fifo_empty;
    fetch_entry_t  head;

    assign instr_valid    = !fifo_empty;
    assign instr          = head.instr;
    assign instr_pc       = head.pc;
    assign pop            = instr_valid && instr_ready;
    assign accept         = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fetch_pc_q;
    assign misaligned_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (redirect_valid) begin
            state_d = is_misaligned(redirect_pc) ? ST_HALT : ST_RUN;
            err_d   = is_misaligned(redirect_pc);
        end
    end

    // Gated by rst_n so the request drops the moment reset asserts, not at the next edge.
    always_comb begin
        credit_used    = {1'b0, count} + {1'b0, inflight_q} - (CW+1)'(pop);
        imem_req_valid = 1'b0;
        if (rst_n && (state_q == ST_RUN) && (credit_used < (CW+1)'(DEPTH))) begin
            imem_req_valid = 1'b1;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        rsp_push   = 1'b0;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
        if (imem_rsp_valid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                rsp_push = 1'b1;
                rsp_pc_d = rsp_pc_q + INSTR_BYTES;
            end
        end
        // Everything still outstanding after this cycle, including a same-cycle accept, is stale.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            err_q      <= err_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push && !fifo_full),
        .push_data ('{pc: rsp_pc_q, instr: imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
